// File: rtl/mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// data access size encodings and requester identifiers.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      ACK  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_lane_merge.sv
// Byte/halfword lane helper: inserts store data into a word for the
// read-modify-write path and extracts a right-aligned, zero-extended
// sub-word for loads. Any size other than byte/half passes the word through.
module mem_lane_merge
   import mem_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_word,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [1:0]       i_size,
   input  logic [1:0]       i_off,
   output logic [WIDTH-1:0] o_merged,
   output logic [WIDTH-1:0] o_extract
);

   // Lane select by byte offset; halfwords use only the upper offset bit.
   always_comb begin
      o_merged  = i_word;
      o_extract = '0;
      case (i_size)
         SZ_BYTE: begin
            o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            o_extract[7:0]                 = i_word[{i_off, 3'b000} +: 8];
         end
         SZ_HALF: begin
            o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            o_extract[15:0]                     = i_word[{i_off[1], 4'b0000} +: 16];
         end
         default: begin
            o_merged  = i_wdata;
            o_extract = i_word;
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for the shared core memory.
// Define MEM_ARBITER_SUBWORD_EN to enable byte/half accesses with
// read-modify-write stores; without it every data access is a word access.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 10,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             if_req_i,
   input  logic [31:0]      if_addr_i,
   output logic             if_ack_o,
   output logic [WIDTH-1:0] if_rdata_o,
   input  logic             d_req_i,
   input  logic             d_we_i,
   input  logic [1:0]       d_size_i,
   input  logic [31:0]      d_addr_i,
   input  logic [WIDTH-1:0] d_wdata_i,
   output logic             d_ack_o,
   output logic             d_err_o,
   output logic [WIDTH-1:0] d_rdata_o,
   output logic             mem_we_o,
   output logic [DEPTH-1:0] mem_waddr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   output logic             mem_re_o,
   output logic [DEPTH-1:0] mem_raddr_o,
   input  logic [WIDTH-1:0] mem_rdata_i
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   state_t           r_state;
   logic [CW-1:0]    r_starve;
   logic             r_gnt;
   logic             r_we;
   logic [DEPTH-1:0] r_addr;
   logic [WIDTH-1:0] r_wdata;

   logic             r_if_ack;
   logic             r_d_ack;
   logic             r_d_err;
   logic [WIDTH-1:0] r_if_rdata;
   logic [WIDTH-1:0] r_d_rdata;
   logic             r_mem_we;
   logic [DEPTH-1:0] r_mem_waddr;
   logic [WIDTH-1:0] r_mem_wdata;
   logic             r_mem_re;
   logic [DEPTH-1:0] r_mem_raddr;

   logic             w_pick_d;
   logic             w_d_mis;
   logic             w_d_rmw;
   logic [DEPTH-1:0] w_if_waddr;
   logic [DEPTH-1:0] w_d_waddr;
   logic [WIDTH-1:0] w_merged;
   logic [WIDTH-1:0] w_extract;
   logic             w_unused;

   assign w_if_waddr = if_addr_i[DEPTH+1:2];
   assign w_d_waddr  = d_addr_i[DEPTH+1:2];

   // Data wins a tie unless fetch has already waited STARVE_MAX data grants.
   assign w_pick_d = d_req_i && (!if_req_i || (r_starve != STARVE_LIM));

`ifdef MEM_ARBITER_SUBWORD_EN
   logic [1:0] r_size;
   logic [1:0] r_off;

   mem_lane_merge #(
      .WIDTH     (WIDTH)
   ) u_lane (
      .i_word    (mem_rdata_i),
      .i_wdata   (r_wdata),
      .i_size    (r_size),
      .i_off     (r_off),
      .o_merged  (w_merged),
      .o_extract (w_extract)
   );

   assign w_unused = ^{if_addr_i[31:DEPTH+2], if_addr_i[1:0], d_addr_i[31:DEPTH+2]};
`else
   assign w_merged  = r_wdata;
   assign w_extract = mem_rdata_i;
   assign w_unused  = ^{if_addr_i[31:DEPTH+2], if_addr_i[1:0], d_addr_i[31:DEPTH+2], d_size_i};
`endif

   // Classify the pending data request: alignment error and whether a store needs RMW.
   always_comb begin
      w_d_mis = |d_addr_i[1:0];
      w_d_rmw = 1'b0;
`ifdef MEM_ARBITER_SUBWORD_EN
      case (d_size_i)
         SZ_BYTE: begin
            w_d_mis = 1'b0;
            w_d_rmw = d_we_i;
         end
         SZ_HALF: begin
            w_d_mis = d_addr_i[0];
            w_d_rmw = d_we_i;
         end
         default: ;
      endcase
`endif
   end

   // Sequencer FSM: grant in IDLE, then read, write and ack phases with registered outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= IDLE;
         r_starve    <= '0;
         r_gnt       <= REQ_IF;
         r_we        <= 1'b0;
         r_if_ack    <= 1'b0;
         r_d_ack     <= 1'b0;
         r_d_err     <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_we    <= 1'b0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
         r_mem_re    <= 1'b0;
         r_mem_raddr <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         r_d_err  <= 1'b0;
         r_mem_we <= 1'b0;
         r_mem_re <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_d) begin
                  r_gnt   <= REQ_D;
                  r_we    <= d_we_i;
                  r_addr  <= w_d_waddr;
                  r_wdata <= d_wdata_i;
`ifdef MEM_ARBITER_SUBWORD_EN
                  r_size  <= d_size_i;
                  r_off   <= d_addr_i[1:0];
`endif
                  if (if_req_i && (r_starve != STARVE_LIM))
                     r_starve <= r_starve + 1'b1;
                  if (w_d_mis) begin
                     r_state   <= ACK;
                     r_d_ack   <= 1'b1;
                     r_d_err   <= 1'b1;
                     r_d_rdata <= '0;
                  end else if (d_we_i && !w_d_rmw) begin
                     r_state     <= WR;
                     r_mem_we    <= 1'b1;
                     r_mem_waddr <= w_d_waddr;
                     r_mem_wdata <= d_wdata_i;
                  end else begin
                     r_state     <= RD;
                     r_mem_re    <= 1'b1;
                     r_mem_raddr <= w_d_waddr;
                  end
               end else if (if_req_i) begin
                  r_gnt       <= REQ_IF;
                  r_we        <= 1'b0;
                  r_addr      <= w_if_waddr;
                  r_starve    <= '0;
                  r_state     <= RD;
                  r_mem_re    <= 1'b1;
                  r_mem_raddr <= w_if_waddr;
               end
            end
            RD: begin
               if ((r_gnt == REQ_D) && r_we) begin
                  r_state     <= WR;
                  r_mem_we    <= 1'b1;
                  r_mem_waddr <= r_addr;
                  r_mem_wdata <= w_merged;
               end else begin
                  r_state <= ACK;
                  if (r_gnt == REQ_IF) begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= mem_rdata_i;
                  end else begin
                     r_d_ack   <= 1'b1;
                     r_d_rdata <= w_extract;
                  end
               end
            end
            WR: begin
               r_state   <= ACK;
               r_d_ack   <= 1'b1;
               r_d_rdata <= '0;
            end
            ACK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign if_ack_o    = r_if_ack;
   assign if_rdata_o  = r_if_rdata;
   assign d_ack_o     = r_d_ack;
   assign d_err_o     = r_d_err;
   assign d_rdata_o   = r_d_rdata;
   // Reset blocks the write strobe immediately, even inside a WR cycle.
   assign mem_we_o    = r_mem_we & rst_ni;
   assign mem_waddr_o = r_mem_waddr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_re_o    = r_mem_re;
   assign mem_raddr_o = r_mem_raddr;

endmodule
